input_act_streamer: RTL
=======================

# input_act_streamer

Parametrised successor to the input activation controller. It buffers externally written activation words in a FIFO and slices each word into OUTPUT_WIDTH elements. It streams an exact, programmed element count per START over a valid/ready handshake with backpressure and a LAST marker. It sits between the AXI-side write path and the MAC array input mapper.

## Interface
Parameters:
- INPUT_WIDTH, 32, FIFO word width; must be an integer multiple of OUTPUT_WIDTH.
- OUTPUT_WIDTH, 8, element width; RATIO = INPUT_WIDTH/OUTPUT_WIDTH, must be ≥ 2.
- FIFO_DEPTH, 64, FIFO words, power of two.
- LEN_WIDTH, 16, width of element count.
- MSB_FIRST, 0, slice order: 0 = element 0 is bits [OUTPUT_WIDTH-1:0]; 1 = element 0 is the top slice.

Ports:
- CLK  in  1  clock; everything on rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- CLEAR_FIFO  in  1  level; rising edge flushes FIFO and aborts the stream.
- START  in  1  level; rising edge requests a stream of LEN elements.
- LEN  in  LEN_WIDTH  element count, sampled on the START edge.
- BUSY  out  1  high from accepted START until DONE/abort.
- DONE  out  1  one-cycle pulse after the last element handshake.
- FIFO_WR_CMD  in  1  write strobe; ignored when FIFO_FULL.
- FIFO_WR_DATA  in  INPUT_WIDTH  write data.
- FIFO_EMPTY  out  1  FIFO empty.
- FIFO_FULL  out  1  FIFO full.
- ACT_DATA  out  OUTPUT_WIDTH  current element.
- ACT_VALID  out  1  ACT_DATA valid.
- ACT_READY  in  1  consumer accepts element.
- ACT_LAST  out  1  high with the final element of the stream.
- ERR  out  3  sticky error flags (only with INPUT_ACT_ERR_EN).

## Operation
- States: IDLE, FETCH, STREAM, ABORT.
- IDLE: a START rising edge with LEN≠0 latches LEN into rem, clears slice index idx, sets BUSY → FETCH. A START edge with LEN=0 produces DONE next cycle and stays IDLE.
- FETCH: asserts the FIFO read when !FIFO_EMPTY. The FIFO returns data one cycle after the read. The word loads into cur_q → STREAM. If empty, waits with ACT_VALID=0 and no timeout.
- STREAM: ACT_VALID=1 and ACT_DATA = slice idx of cur_q, reordered per MSB_FIRST. On ACT_VALID&ACT_READY: idx++ and rem--.
- Prefetch: when cur_q is loaded and the FIFO is non-empty, one more word is read into nxt_q (nxt_vld). At the handshake of slice RATIO-1, nxt_q moves to cur_q with no bubble. If nxt_vld=0, go to FETCH (ACT_VALID drops).
- ACT_LAST = (rem==1) in STREAM. The handshake on LAST → DONE pulse and IDLE, BUSY=0. Unused slices of the final partial word and any prefetched nxt_q are discarded, not returned to the FIFO.
- ACT_DATA/ACT_VALID hold stable while ACT_VALID&!ACT_READY.
- START edges while BUSY are ignored.
- CLEAR_FIFO rising edge: the next cycle is ABORT, which flushes the FIFO, drops nxt_vld/ACT_VALID and BUSY with no DONE, then returns to IDLE. A write in the same cycle as the flush is lost.

## Timing
- Reset values: BUSY=0, DONE=0, ACT_VALID=0, ACT_LAST=0, ACT_DATA=0, FIFO_EMPTY=1, FIFO_FULL=0, ERR=0. State resets to IDLE with rem/idx=0.
- START edge sampled at edge T, FIFO non-empty: read at T+1, cur_q loaded at T+2, ACT_VALID=1 during cycle after T+2 (latency 3 edges).
- Throughput: 1 element/cycle while ACT_READY=1 and FIFO keeps ≥1 word ahead.
- Empty between words: ACT_VALID low for ≥2 cycles after a word arrives before resuming.
- CLEAR edge at T: ABORT in cycle after T; FIFO_EMPTY=1 and BUSY=0 after T+2.
- Reset mid-stream: all outputs go to reset values immediately (asynchronous), with no DONE.

## Configuration
- INPUT_ACT_ERR_EN defined: ERR is sticky, cleared only by reset or a CLEAR edge.
  - bit0: write while FULL.
  - bit1: START edge while BUSY.
  - bit2: START edge with LEN=0.
- Not defined: ERR is tied to 0 and no detection logic is built.

## Structure
- Package input_act_pkg: state enum typedef (IDLE, FETCH, STREAM, ABORT), ERR bit index constants.
- RATIO and the idx width ($clog2(RATIO)) are module localparams.
- One sub-module: the existing fifo (FIFO_WIDTH=INPUT_WIDTH, FIFO_DEPTH). Its reset is driven by RESETN & ~flush.

## Test plan
- Write 0x44332211, 0x88776655; START with LEN=8, ACT_READY=1 → ACT_DATA 11,22,…,88 on 8 consecutive cycles, LAST on 88, DONE next cycle, FIFO_EMPTY=1.
- MSB_FIRST=1, write 0xAABBCCDD, LEN=4 → DD appears last: AA,BB,CC,DD.
- LEN=5 with two words, ACT_READY toggled 1,0,1,0 → 5 elements with data held while stalled, LAST on 5th, remaining 3 slices discarded, FIFO empty.
- START with empty FIFO, write a word 10 cycles later → ACT_VALID rises 2 cycles after the write; no error.
- CLEAR_FIFO edge mid-stream after 3 elements → ACT_VALID=0, BUSY=0, no DONE, FIFO_EMPTY=1 within 2 cycles.
- With INPUT_ACT_ERR_EN: fill 64 words, one extra write, START while BUSY → ERR=3'b011; CLEAR edge → ERR=0.

Source files
------------

// File: rtl/input_act_pkg.sv
// input_act_pkg: streamer FSM states and ERR flag bit positions.
package input_act_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, ABORT} state_t;
    localparam int ERR_WR_FULL    = 0;
    localparam int ERR_START_BUSY = 1;
    localparam int ERR_LEN_ZERO   = 2;
endpackage

// File: rtl/fifo.sv
// fifo: single-clock FIFO with registered read data (data appears the cycle after a read).
module fifo #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [FIFO_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [FIFO_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] cnt_q;
    logic wr, rd;
    assign full_o  = cnt_q == FULL_CNT;
    assign empty_o = cnt_q == '0;
    assign wr = wr_en_i & ~full_o;
    assign rd = rd_en_i & ~empty_o;
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_data_o <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_o <= mem_q[rd_ptr_q];
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
endmodule

// File: rtl/input_act_streamer.sv
// input_act_streamer: buffers activation words and streams LEN sliced elements per START.
// Sticky ERR flags are built only when INPUT_ACT_ERR_EN is defined.
module input_act_streamer
    import input_act_pkg::*;
#(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter int LEN_WIDTH    = 16,
    parameter int MSB_FIRST    = 0
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    CLEAR_FIFO,
    input  logic                    START,
    input  logic [LEN_WIDTH-1:0]    LEN,
    output logic                    BUSY,
    output logic                    DONE,
    input  logic                    FIFO_WR_CMD,
    input  logic [INPUT_WIDTH-1:0]  FIFO_WR_DATA,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic [OUTPUT_WIDTH-1:0] ACT_DATA,
    output logic                    ACT_VALID,
    input  logic                    ACT_READY,
    output logic                    ACT_LAST,
    output logic [2:0]              ERR
);
    localparam int RATIO = INPUT_WIDTH / OUTPUT_WIDTH;
    localparam int IDXW  = $clog2(RATIO);
    state_t state_q;
    logic start_q, clear_q, busy_q, done_q, nxt_vld_q, rd_pend_q;
    logic [LEN_WIDTH-1:0] rem_q;
    logic [IDXW-1:0] idx_q, sel;
    logic [INPUT_WIDTH-1:0] cur_q, nxt_q, rd_data;
    logic [RATIO-1:0][OUTPUT_WIDTH-1:0] slices;
    logic start_rise, clear_rise, flush, rd, hs, word_end, fifo_rst_n;

    assign start_rise = START & ~start_q;
    assign clear_rise = CLEAR_FIFO & ~clear_q;
    assign flush      = state_q == ABORT;
    assign fifo_rst_n = RESETN & ~flush;
    assign hs         = ACT_VALID & ACT_READY;
    assign word_end   = idx_q == IDXW'(RATIO - 1);
    // One read in flight at a time; in STREAM it only refills the empty prefetch slot.
    assign rd = !FIFO_EMPTY && !rd_pend_q && (state_q == FETCH || (state_q == STREAM && !nxt_vld_q));
    assign slices    = cur_q;
    assign sel       = (MSB_FIRST != 0) ? IDXW'(RATIO - 1) - idx_q : idx_q;
    assign ACT_DATA  = slices[sel];
    assign ACT_VALID = state_q == STREAM;
    assign ACT_LAST  = ACT_VALID && rem_q == LEN_WIDTH'(1);
    assign BUSY      = busy_q;
    assign DONE      = done_q;

    fifo #(
        .FIFO_WIDTH (INPUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (fifo_rst_n),
        .wr_en_i   (FIFO_WR_CMD),
        .wr_data_i (FIFO_WR_DATA),
        .rd_en_i   (rd),
        .rd_data_o (rd_data),
        .empty_o   (FIFO_EMPTY),
        .full_o    (FIFO_FULL)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nxt_vld_q <= 1'b0;
            rd_pend_q <= 1'b0;
            rem_q     <= '0;
            idx_q     <= '0;
            cur_q     <= '0;
            nxt_q     <= '0;
        end else begin
            start_q   <= START;
            clear_q   <= CLEAR_FIFO;
            done_q    <= 1'b0;
            rd_pend_q <= rd;
            if (clear_rise) begin
                state_q   <= ABORT;
                busy_q    <= 1'b0;
                nxt_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_rise) begin
                        if (LEN == '0) done_q <= 1'b1;
                        else begin
                            state_q   <= FETCH;
                            busy_q    <= 1'b1;
                            rem_q     <= LEN;
                            idx_q     <= '0;
                            nxt_vld_q <= 1'b0;
                        end
                    end
                    FETCH: if (rd_pend_q) begin
                        cur_q   <= rd_data;
                        state_q <= STREAM;
                    end
                    STREAM: begin
                        if (rd_pend_q && !(hs && word_end)) begin
                            nxt_q     <= rd_data;
                            nxt_vld_q <= 1'b1;
                        end
                        if (hs) begin
                            rem_q <= rem_q - 1'b1;
                            idx_q <= word_end ? '0 : idx_q + 1'b1;
                            if (ACT_LAST) begin
                                state_q   <= IDLE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                nxt_vld_q <= 1'b0;
                            end else if (word_end) begin
                                if (nxt_vld_q) begin
                                    cur_q     <= nxt_q;
                                    nxt_vld_q <= 1'b0;
                                end else if (rd_pend_q) cur_q <= rd_data;
                                else state_q <= FETCH;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef INPUT_ACT_ERR_EN
    logic [2:0] err_q, err_set;
    assign err_set[ERR_WR_FULL]    = FIFO_WR_CMD && FIFO_FULL;
    assign err_set[ERR_START_BUSY] = start_rise && busy_q;
    assign err_set[ERR_LEN_ZERO]   = start_rise && LEN == '0;
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) err_q <= '0;
        else if (clear_rise) err_q <= '0;
        else err_q <= err_q | err_set;
    end
    assign ERR = err_q;
`else
    assign ERR = 3'b000;
`endif
endmodule
